// File: rtl/hex_scroll_ctrl.sv
// Scroll sequencer for the 4-position HEX rotating message.
// Drives the rotation select from a prescaled tick or manual steps.
module hex_scroll_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   localparam int CW = $clog2(TICK_DIV)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_en,
   input  logic       step,
   input  logic       dir,
   input  logic       load,
   input  logic [7:0] chars_in,
   output logic [7:0] chars_out,
   output logic [1:0] sel_out,
   output logic       tick_out,
   output logic [1:0] state_out
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0]    sel_nxt;
   logic          step_q;
   logic          step_edge;
   logic          adv;

   assign step_edge = step & ~step_q;
   assign state_out = state;

   // State, prescaler, select and message registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_out   <= 2'd0;
         chars_out <= 8'd0;
         step_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         sel_out <= sel_nxt;
         step_q <= step;
         if (load)
            chars_out <= chars_in;
      end
   end

   // Next state, tick detection, advance and prescaler update
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      sel_nxt   = sel_out;
      tick_out  = 1'b0;
      adv       = 1'b0;

      if (state == RUN && cnt == LAST)
         tick_out = 1'b1;

      // Steps during RUN are dropped, not queued
      if (tick_out || (step_edge && state != RUN))
         adv = 1'b1;

      if (state == RUN && !tick_out)
         cnt_nxt = cnt + 1'b1;

      unique case (state)
         IDLE:    state_nxt = run_en ? RUN : IDLE;
         RUN:     state_nxt = run_en ? RUN : HOLD;
         HOLD:    state_nxt = run_en ? RUN : HOLD;
         default: state_nxt = IDLE;
      endcase

      if (adv)
         sel_nxt = dir ? sel_out - 2'd1 : sel_out + 2'd1;

      // Load overrides any advance and restarts the sequence
      if (load) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         sel_nxt   = 2'd0;
      end
   end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with TICK_DIV=4.
// Expected values are hand-computed per step.
module tb_hex_scroll_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_en;
   logic       step;
   logic       dir;
   logic       load;
   logic [7:0] chars_in;
   logic [7:0] chars_out;
   logic [1:0] sel_out;
   logic       tick_out;
   logic [1:0] state_out;

   int n_vec = 0;
   int n_err = 0;

   hex_scroll_ctrl #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run_en    (run_en),
      .step      (step),
      .dir       (dir),
      .load      (load),
      .chars_in  (chars_in),
      .chars_out (chars_out),
      .sel_out   (sel_out),
      .tick_out  (tick_out),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // From RUN with count 0: three quiet cycles, tick, then new select
   task automatic run_period(input string tag, input logic [1:0] pre,
                             input logic [1:0] post);
      chk({tag, "_t0"}, 8'(tick_out), 8'd0);
      cyc();
      chk({tag, "_t1"}, 8'(tick_out), 8'd0);
      cyc();
      chk({tag, "_t2"}, 8'(tick_out), 8'd0);
      cyc();
      chk({tag, "_tick"}, 8'(tick_out), 8'd1);
      chk({tag, "_pre"}, 8'(sel_out), 8'(pre));
      cyc();
      chk({tag, "_sel"}, 8'(sel_out), 8'(post));
   endtask

   initial begin
      rst = 1'b1; run_en = 1'b0; step = 1'b0;
      dir = 1'b0; load = 1'b0; chars_in = 8'h00;
      #1;
      cyc();
      cyc();
      chk("rst_sel", 8'(sel_out), 8'd0);
      chk("rst_chars", chars_out, 8'h00);
      chk("rst_tick", 8'(tick_out), 8'd0);
      chk("rst_state", 8'(state_out), 8'd0);

      // Forward scroll
      rst = 1'b0; load = 1'b1; chars_in = 8'h1B; run_en = 1'b1;
      cyc();
      chk("ld_chars", chars_out, 8'h1B);
      chk("ld_state", 8'(state_out), 8'd0);
      load = 1'b0;
      cyc();
      chk("run_state", 8'(state_out), 8'd1);
      chk("run_sel0", 8'(sel_out), 8'd0);
      run_period("fw1", 2'd0, 2'd1);
      run_period("fw2", 2'd1, 2'd2);
      run_period("fw3", 2'd2, 2'd3);
      run_period("fw4", 2'd3, 2'd0);

      // Reverse scroll after reload
      load = 1'b1; dir = 1'b1;
      cyc();
      chk("rl_state", 8'(state_out), 8'd0);
      load = 1'b0;
      cyc();
      run_period("rv1", 2'd0, 2'd3);
      run_period("rv2", 2'd3, 2'd2);
      run_period("rv3", 2'd2, 2'd1);
      run_period("rv4", 2'd1, 2'd0);

      // Hold at prescaler=2, resume gives full period
      dir = 1'b0;
      cyc();
      cyc();
      run_en = 1'b0;
      cyc();
      chk("hold_state", 8'(state_out), 8'd2);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("hold_tick", 8'(tick_out), 8'd0);
      end
      chk("hold_sel", 8'(sel_out), 8'd0);
      run_en = 1'b1;
      cyc();
      chk("resume_state", 8'(state_out), 8'd1);
      run_period("res", 2'd0, 2'd1);

      // Held step advances once in HOLD
      run_en = 1'b0;
      cyc();
      chk("h2_state", 8'(state_out), 8'd2);
      step = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      chk("step_once", 8'(sel_out), 8'd2);
      step = 1'b0;
      cyc();

      // Step edge in RUN is discarded
      run_en = 1'b1;
      cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
      chk("run_step", 8'(sel_out), 8'd2);
      cyc();
      chk("ldt_tick", 8'(tick_out), 8'd1);

      // Load in the tick cycle wins
      load = 1'b1; chars_in = 8'hE4;
      cyc();
      chk("ldt_chars", chars_out, 8'hE4);
      chk("ldt_sel", 8'(sel_out), 8'd0);
      chk("ldt_state", 8'(state_out), 8'd0);
      load = 1'b0;
      cyc();
      chk("ldt_run", 8'(state_out), 8'd1);

      // Step in IDLE with dir=1 wraps 0->3
      run_en = 1'b0; load = 1'b1;
      cyc();
      load = 1'b0; dir = 1'b1; step = 1'b1;
      cyc();
      chk("idle_wrap", 8'(sel_out), 8'd3);
      step = 1'b0;

      // Reset mid-count clears everything
      run_en = 1'b1;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      chk("mrst_sel", 8'(sel_out), 8'd0);
      chk("mrst_chars", chars_out, 8'h00);
      chk("mrst_state", 8'(state_out), 8'd0);
      chk("mrst_tick", 8'(tick_out), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
